matmul_tiled_engine: RTL and testbench

Next-generation parametrised matrix-multiply engine that computes C[m x p] = A[m x n] * B[n x p] for runtime-configurable m, n, p.
- Operands are written element-by-element into internal register buffers, then the engine is started.
- Compute runs as a multi-cycle accumulation using LANES parallel MACs.
- Results stream out as one LANES-wide output column group per beat under a valid/ready handshake.
- Sits between the feature-map buffer and the activation/writeback stage of the accelerator.

---
 rtl/matmul_tiled_engine.sv | 229 ++++++++++++++++++++++
 tb/tb_matmul_tiled_engine.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matmul_tiled_engine.sv
// matmul_tiled_engine
// Computes C[m x p] = A[m x n] * B[n x p] with runtime m, n, p. Operands are
// written element-by-element into internal buffers while idle; a start pulse
// launches the run. Each output beat carries one LANES-wide column group of
// one row of C and takes n MAC cycles plus one handshake cycle.
// Optional build macro: MATMUL_RELU_SAT_EN (ReLU and saturation to the
// positive signed BITS range on every output lane).

module matmul_tiled_engine #(
  parameter int BITS     = 8,
  parameter int DIM      = 32,
  parameter int KDIM     = 64,
  parameter int LANES    = 4,
  parameter int ACC_BITS = 2*BITS + $clog2(KDIM)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [$clog2(DIM):0]      cfg_m,
  input  logic [$clog2(KDIM):0]     cfg_n,
  input  logic [$clog2(DIM):0]      cfg_p,
  input  logic                      start,
  output logic                      busy,
  output logic                      done,
  output logic                      err,
  input  logic                      wr_en,
  input  logic                      wr_sel,
  input  logic [$clog2(KDIM)-1:0]   wr_row,
  input  logic [$clog2(KDIM)-1:0]   wr_col,
  input  logic signed [BITS-1:0]    wr_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [$clog2(DIM)-1:0]    out_row,
  output logic [$clog2(DIM)-1:0]    out_col,
  output logic [LANES-1:0]          out_mask,
  output logic [LANES*ACC_BITS-1:0] out_data,
  output logic                      out_last
);

  localparam int DW = $clog2(DIM);
  localparam int KW = $clog2(KDIM);
  localparam int PW = 2*BITS;

  localparam logic [DW:0]   MAX_MP  = (DW+1)'(DIM);
  localparam logic [KW:0]   MAX_N   = (KW+1)'(KDIM);
  localparam logic [KW:0]   DIM_K   = (KW+1)'(DIM);
  localparam logic [DW+1:0] LANES_W = (DW+2)'(LANES);

`ifdef MATMUL_RELU_SAT_EN
  localparam logic signed [ACC_BITS-1:0] SAT_MAX = ACC_BITS'((1 << (BITS-1)) - 1);
`endif

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    OUT,
    DONE
  } stateT;

  stateT state;
  stateT stateNext;

  // Latched run configuration and loop indices
  logic [DW:0]   cfgM;
  logic [KW:0]   cfgN;
  logic [DW:0]   cfgP;
  logic [DW-1:0] rowI;
  logic [DW-1:0] colJ;
  logic [KW-1:0] kIdx;
  logic          errQ;

  logic signed [ACC_BITS-1:0] acc [LANES];

  // Operand storage: A is DIM x KDIM, B is KDIM x DIM
  logic signed [BITS-1:0] bufA [DIM][KDIM];
  logic signed [BITS-1:0] bufB [KDIM][DIM];

  // Datapath helpers
  logic                   cfgOk;
  logic                   inOut;
  logic [DW+1:0]          jPlusLanes;
  logic                   moreCols;
  logic                   lastBeat;
  logic                   lastK;
  logic signed [BITS-1:0] aElem;
  logic [DW-1:0]          colIdx [LANES];
  logic signed [PW-1:0]   prod [LANES];
  logic [LANES-1:0]       laneMask;

  assign cfgOk = (cfg_m != '0) && (cfg_m <= MAX_MP) &&
                 (cfg_n != '0) && (cfg_n <= MAX_N)  &&
                 (cfg_p != '0) && (cfg_p <= MAX_MP);

  assign inOut      = (state == OUT);
  assign jPlusLanes = {2'b0, colJ} + LANES_W;
  assign moreCols   = jPlusLanes < {1'b0, cfgP};
  assign lastBeat   = ({1'b0, rowI} == cfgM - (DW+1)'(1)) && !moreCols;
  assign lastK      = ({1'b0, kIdx} == cfgN - (KW+1)'(1));

  // Operand writes, accepted only while idle and only for in-range indices
  // NOTE: the operand buffers carry no reset; their contents must survive a
  // reset so a rerun needs no reload, and reset-free storage maps onto RAM.
  always_ff @(posedge clk) begin
    if (state == IDLE && wr_en) begin
      if (!wr_sel) begin
        if ({1'b0, wr_row} < DIM_K && {1'b0, wr_col} < MAX_N)
          bufA[wr_row[DW-1:0]][wr_col] <= wr_data;
      end else begin
        if ({1'b0, wr_row} < MAX_N && {1'b0, wr_col} < DIM_K)
          bufB[wr_row][wr_col[DW-1:0]] <= wr_data;
      end
    end
  end

  // Per-lane products of A[i][k] and B[k][j+l]; masked lanes contribute 0
  // NOTE: every combinational output gets a default before any branch, so no
  // path leaves a value unassigned and no latch is inferred.
  always_comb begin
    aElem    = bufA[rowI][kIdx];
    laneMask = '0;
    for (int l = 0; l < LANES; l++) begin
      colIdx[l]   = colJ + DW'(l);
      laneMask[l] = ({2'b0, colJ} + (DW+2)'(l)) < {1'b0, cfgP};
      if (laneMask[l])
        prod[l] = PW'(aElem) * PW'(bufB[kIdx][colIdx[l]]);
      else
        prod[l] = '0;
    end
  end

  // State register
  // NOTE: sequential logic uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= stateNext;
  end

  // Next-state logic
  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (start && cfgOk) stateNext = MAC;
      MAC:     if (lastK) stateNext = OUT;
      OUT:     if (out_ready) stateNext = lastBeat ? DONE : MAC;
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Config latch, loop indices, accumulators and the reject pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfgM <= '0;
      cfgN <= '0;
      cfgP <= '0;
      rowI <= '0;
      colJ <= '0;
      kIdx <= '0;
      errQ <= 1'b0;
      for (int l = 0; l < LANES; l++) acc[l] <= '0;
    end else begin
      errQ <= (state == IDLE) && start && !cfgOk;
      case (state)
        IDLE: begin
          if (start && cfgOk) begin
            cfgM <= cfg_m;
            cfgN <= cfg_n;
            cfgP <= cfg_p;
            rowI <= '0;
            colJ <= '0;
            kIdx <= '0;
            for (int l = 0; l < LANES; l++) acc[l] <= '0;
          end
        end
        MAC: begin
          for (int l = 0; l < LANES; l++) acc[l] <= acc[l] + ACC_BITS'(prod[l]);
          kIdx <= kIdx + KW'(1);
        end
        OUT: begin
          if (out_ready) begin
            for (int l = 0; l < LANES; l++) acc[l] <= '0;
            kIdx <= '0;
            if (moreCols) begin
              colJ <= colJ + DW'(LANES);
            end else begin
              colJ <= '0;
              rowI <= rowI + DW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Output lane post-processing (raw, or ReLU + saturation when enabled)
  function automatic logic [ACC_BITS-1:0] postProc(input logic signed [ACC_BITS-1:0] v);
`ifdef MATMUL_RELU_SAT_EN
    if (v[ACC_BITS-1])   return '0;
    else if (v > SAT_MAX) return SAT_MAX;
    else                 return v;
`else
    return v;
`endif
  endfunction

  // Status and output beat, all zero outside the OUT state
  always_comb begin
    busy      = (state == MAC) || (state == OUT);
    done      = (state == DONE);
    err       = errQ;
    out_valid = inOut;
    out_row   = '0;
    out_col   = '0;
    out_mask  = '0;
    out_last  = 1'b0;
    out_data  = '0;
    if (inOut) begin
      out_row  = rowI;
      out_col  = colJ;
      out_mask = laneMask;
      out_last = lastBeat;
      for (int l = 0; l < LANES; l++) begin
        if (laneMask[l]) out_data[l*ACC_BITS +: ACC_BITS] = postProc(acc[l]);
      end
    end
  end

endmodule

// File: tb/tb_matmul_tiled_engine.sv
// Testbench for matmul_tiled_engine: table-driven single-beat vectors plus
// hand-written sequences for identity timing, stalls, bad configs, reset
// mid-run and write ordering. Honours MATMUL_RELU_SAT_EN when defined.

module tb_matmul_tiled_engine;

  localparam int BITS     = 8;
  localparam int DIM      = 32;
  localparam int KDIM     = 64;
  localparam int LANES    = 4;
  localparam int ACC_BITS = 2*BITS + $clog2(KDIM);
  localparam int DW       = $clog2(DIM);
  localparam int KW       = $clog2(KDIM);

  logic                      clk = 1'b0;
  logic                      rst_n;
  logic [DW:0]               cfg_m;
  logic [KW:0]               cfg_n;
  logic [DW:0]               cfg_p;
  logic                      start;
  logic                      busy;
  logic                      done;
  logic                      err;
  logic                      wr_en;
  logic                      wr_sel;
  logic [KW-1:0]             wr_row;
  logic [KW-1:0]             wr_col;
  logic signed [BITS-1:0]    wr_data;
  logic                      out_valid;
  logic                      out_ready;
  logic [DW-1:0]             out_row;
  logic [DW-1:0]             out_col;
  logic [LANES-1:0]          out_mask;
  logic [LANES*ACC_BITS-1:0] out_data;
  logic                      out_last;

  matmul_tiled_engine #(
    .BITS(BITS), .DIM(DIM), .KDIM(KDIM), .LANES(LANES), .ACC_BITS(ACC_BITS)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_m(cfg_m), .cfg_n(cfg_n), .cfg_p(cfg_p),
    .start(start), .busy(busy), .done(done), .err(err),
    .wr_en(wr_en), .wr_sel(wr_sel), .wr_row(wr_row), .wr_col(wr_col), .wr_data(wr_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_row(out_row), .out_col(out_col), .out_mask(out_mask),
    .out_data(out_data), .out_last(out_last)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int               row;
    int               col;
    logic [LANES-1:0] mask;
    int               d [LANES];
    bit               last;
  } beatT;

  typedef struct {
    string            name;
    int               n;
    int               p;
    int               a [3];
    int               b [12];
    int               raw [LANES];
    logic [LANES-1:0] mask;
  } vecT;

  beatT expQ [$];
  int   nChecks = 0;
  int   nErrors = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErrors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  function automatic int expLane(input int raw);
`ifdef MATMUL_RELU_SAT_EN
    if (raw < 0)   return 0;
    if (raw > 127) return 127;
    return raw;
`else
    return raw;
`endif
  endfunction

  function automatic logic [LANES*ACC_BITS-1:0] packLanes(input int d [LANES]);
    logic [LANES*ACC_BITS-1:0] r;
    r = '0;
    for (int l = 0; l < LANES; l++) r[l*ACC_BITS +: ACC_BITS] = ACC_BITS'(expLane(d[l]));
    return r;
  endfunction

  task automatic writeElem(input bit sel, input int row, input int col, input int data);
    wr_en   = 1'b1;
    wr_sel  = sel;
    wr_row  = KW'(row);
    wr_col  = KW'(col);
    wr_data = BITS'(data);
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  task automatic pushBeat(input int row, input int col, input logic [LANES-1:0] mask,
                          input int d0, input int d1, input int d2, input int d3, input bit last);
    beatT b;
    b.row  = row;
    b.col  = col;
    b.mask = mask;
    b.d    = '{d0, d1, d2, d3};
    b.last = last;
    expQ.push_back(b);
  endtask

  task automatic loadIdentity();
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        writeElem(1'b0, r, c, (r == c) ? 1 : 0);
        writeElem(1'b1, r, c, r*4 + c);
      end
    end
  endtask

  // Expected beats of A*B with A = identity except A[0][0] = a00
  task automatic fillIdentity(input int a00);
    for (int r = 0; r < 4; r++) begin
      int s;
      s = (r == 0) ? a00 : 1;
      pushBeat(r, 0, 4'b1111, s*(4*r), s*(4*r+1), s*(4*r+2), s*(4*r+3), r == 3);
    end
  endtask

  // Launch one run and compare every accepted beat against expQ
  task automatic runCheck(input string tag, input int m, input int n, input int p,
                          input bit toggle, input bit timing, input bit wrStart, input bit wrBusy);
    int           beatIdx;
    int           nBeats;
    int           startCyc;
    bit           seenValid;
    bit           gotDone;
    bit           held;
    logic [127:0] heldSnap;
    beatT         b;
    beatIdx   = 0;
    seenValid = 1'b0;
    gotDone   = 1'b0;
    held      = 1'b0;
    heldSnap  = '0;
    nBeats    = expQ.size();
    cfg_m     = (DW+1)'(m);
    cfg_n     = (KW+1)'(n);
    cfg_p     = (DW+1)'(p);
    start     = 1'b1;
    out_ready = 1'b1;
    if (wrStart) begin
      wr_en = 1'b1; wr_sel = 1'b0; wr_row = '0; wr_col = '0; wr_data = 8'sd5;
    end
    startCyc = cyc;
    @(negedge clk);
    start = 1'b0;
    wr_en = 1'b0;
    check({tag, "_busy"}, busy, 1);
    for (int t = 0; t < 2000 && !gotDone; t++) begin
      out_ready = toggle ? t[0] : 1'b1;
      if (wrBusy && t == 0) begin
        wr_en = 1'b1; wr_sel = 1'b0; wr_row = '0; wr_col = '0; wr_data = 8'sd5;
        start = 1'b1; cfg_n = '0;
      end else begin
        wr_en = 1'b0;
        start = 1'b0;
      end
      if (wrBusy && t == 1) check({tag, "_no_err_busy"}, err, 0);
      if (held) begin
        check({tag, "_stall_hold"},
              {out_valid, out_row, out_col, out_mask, out_last, out_data}, heldSnap);
        held = 1'b0;
      end
      if (done) begin
        gotDone = 1'b1;
        check({tag, "_beats"}, beatIdx, nBeats);
        check({tag, "_done_busy"}, busy, 0);
        if (timing) check({tag, "_done_cyc"}, cyc - startCyc,
                          m * ((p + LANES - 1) / LANES) * (n + 1) + 1);
      end else if (out_valid) begin
        if (!seenValid && timing) check({tag, "_first_valid_cyc"}, cyc - startCyc, n + 1);
        seenValid = 1'b1;
        if (out_ready) begin
          check($sformatf("%s_b%0d_in_range", tag, beatIdx), beatIdx < nBeats, 1);
          if (beatIdx < nBeats) begin
            b = expQ[beatIdx];
            check($sformatf("%s_b%0d_pos", tag, beatIdx), {out_row, out_col},
                  {DW'(b.row), DW'(b.col)});
            check($sformatf("%s_b%0d_mask", tag, beatIdx), out_mask, b.mask);
            check($sformatf("%s_b%0d_last", tag, beatIdx), out_last, b.last);
            check($sformatf("%s_b%0d_data", tag, beatIdx), out_data, packLanes(b.d));
          end
          beatIdx++;
        end else begin
          held     = 1'b1;
          heldSnap = {out_valid, out_row, out_col, out_mask, out_last, out_data};
        end
      end
      if (!gotDone) @(negedge clk);
    end
    wr_en = 1'b0;
    start = 1'b0;
    check({tag, "_completed"}, gotDone, 1);
    if (gotDone) begin
      @(negedge clk);
      check({tag, "_done_one_cycle"}, {done, busy}, 0);
    end
    out_ready = 1'b1;
    expQ.delete();
  endtask

  initial begin
    vecT vecs [4];
    bit  seen;

    vecs[0] = '{"sgn_max", 3, 1, '{-128, -128, 127},
                '{-128, 0, 0, 0, -128, 0, 0, 0, 127, 0, 0, 0}, '{48897, 0, 0, 0}, 4'b0001};
    vecs[1] = '{"sgn_neg", 3, 1, '{-1, -1, -1},
                '{1, 9, 9, 9, 1, 9, 9, 9, 1, 9, 9, 9}, '{-3, 0, 0, 0}, 4'b0001};
    vecs[2] = '{"mix_p3", 2, 3, '{2, -3, 0},
                '{1, 2, 3, 7, 4, -5, 6, 7, 0, 0, 0, 0}, '{-10, 19, -12, 0}, 4'b0111};
    vecs[3] = '{"wide_p4", 1, 4, '{10, 0, 0},
                '{1, -2, 3, 20, 0, 0, 0, 0, 0, 0, 0, 0}, '{10, -20, 30, 200}, 4'b1111};

    rst_n = 1'b1; cfg_m = '0; cfg_n = '0; cfg_p = '0; start = 1'b0;
    wr_en = 1'b0; wr_sel = 1'b0; wr_row = '0; wr_col = '0; wr_data = '0; out_ready = 1'b0;
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_outputs",
          {busy, done, err, out_valid, out_row, out_col, out_mask, out_last, out_data}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_after_reset", {busy, done, err, out_valid}, 0);

    // Single-beat vectors (m = 1)
    for (int v = 0; v < 4; v++) begin
      for (int k = 0; k < vecs[v].n; k++) begin
        writeElem(1'b0, 0, k, vecs[v].a[k]);
        for (int c = 0; c < 4; c++) writeElem(1'b1, k, c, vecs[v].b[k*4 + c]);
      end
      pushBeat(0, 0, vecs[v].mask, vecs[v].raw[0], vecs[v].raw[1],
               vecs[v].raw[2], vecs[v].raw[3], 1'b1);
      runCheck(vecs[v].name, 1, vecs[v].n, vecs[v].p, 1'b0, 1'b1, 1'b0, 1'b0);
    end

    // Identity with full timing, then a run with an ignored write and start
    loadIdentity();
    fillIdentity(1);
    runCheck("ident", 4, 4, 4, 1'b0, 1'b1, 1'b0, 1'b0);
    fillIdentity(1);
    runCheck("busy_wr", 4, 4, 4, 1'b0, 1'b1, 1'b0, 1'b1);

    // Rejected configurations
    cfg_m = 1; cfg_n = 0; cfg_p = 1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("bad_n_err", {err, busy, out_valid}, 3'b100);
    @(negedge clk);
    check("bad_n_err_clear", {err, busy, out_valid}, 3'b000);
    cfg_m = 1; cfg_n = 1; cfg_p = 33; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("bad_p_err", {err, busy, out_valid}, 3'b100);
    @(negedge clk);
    check("bad_p_err_clear", {err, busy, out_valid}, 3'b000);

    // Reset during the second beat's MAC phase, then rerun without reloading
    cfg_m = 4; cfg_n = 4; cfg_p = 4; start = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seen = 1'b0;
    for (int t = 0; t < 50 && !seen; t++) begin
      if (out_valid) seen = 1'b1;
      @(negedge clk);
    end
    check("rstmid_first_beat", seen, 1);
    @(negedge clk);
    check("rstmid_busy_before", busy, 1);
    rst_n = 1'b0;
    #1;
    check("rstmid_outputs",
          {busy, done, err, out_valid, out_row, out_col, out_mask, out_last, out_data}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    fillIdentity(1);
    runCheck("rstmid_rerun", 4, 4, 4, 1'b0, 1'b1, 1'b0, 1'b0);

    // Write in the same cycle as start is visible to the run
    fillIdentity(5);
    runCheck("start_wr", 4, 4, 4, 1'b0, 1'b1, 1'b1, 1'b0);

    // Backpressure: 2x2 * 2x6, out_ready toggling
    writeElem(1'b0, 0, 0, 1);
    writeElem(1'b0, 0, 1, 2);
    writeElem(1'b0, 1, 0, 3);
    writeElem(1'b0, 1, 1, -1);
    for (int c = 0; c < 6; c++) begin
      writeElem(1'b1, 0, c, c + 1);
      writeElem(1'b1, 1, c, c - 1);
    end
    pushBeat(0, 0, 4'b1111, -1,  2,  5,  8, 1'b0);
    pushBeat(0, 4, 4'b0011, 11, 14,  0,  0, 1'b0);
    pushBeat(1, 0, 4'b1111,  4,  6,  8, 10, 1'b0);
    pushBeat(1, 4, 4'b0011, 12, 14,  0,  0, 1'b1);
    runCheck("bp", 2, 2, 6, 1'b1, 1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", nChecks);
    $fatal(1, "watchdog");
  end

endmodule
